// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// handshake level names.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_ANNUL            = 1'b1;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: trial-subtract the divisor magnitude from
// the upper half of the work register and shift in the quotient bit.
module div_seq_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]   work,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W:0]   work_nxt
);

    logic [DATA_W:0] diff;

    // Negative trial difference keeps the partial remainder (quotient bit 0),
    // otherwise the difference replaces it (quotient bit 1).
    always_comb begin
        diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
        if (diff[DATA_W]) begin
            work_nxt = {work[2*DATA_W-1:0], 1'b0};
        end else begin
            work_nxt = {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Operands are reduced to
// magnitudes on accept, DATA_W iterations run one per clock, and the signs
// are reapplied when the result is registered.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int WORK_W = 2*DATA_W + 1;

    div_state_t           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [WORK_W-1:0]    work_reg, work_next;
    logic [DATA_W-1:0]    b_mag_reg, b_mag_next;
    logic                 signed_reg, signed_next;
    logic                 a_msb_reg, a_msb_next;
    logic                 b_msb_reg, b_msb_next;
    logic [2*DATA_W-1:0]  result_reg, result_next;
    logic                 ready_reg, ready_next;

    logic [WORK_W-1:0]    step_work;
    logic [DATA_W-1:0]    a_mag, b_mag;
    logic [DATA_W-1:0]    q_raw, r_raw, q_fix, r_fix;

    div_seq_step #(.DATA_W(DATA_W)) u_step (
        .work     (work_reg),
        .divisor  (b_mag_reg),
        .work_nxt (step_work)
    );

    // Operand magnitudes at accept time and sign fix-up of the finished result.
    // Negating 0x80..0 wraps to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        q_raw = work_reg[DATA_W-1:0];
        r_raw = work_reg[2*DATA_W:DATA_W+1];
        q_fix = (signed_reg && (a_msb_reg ^ b_msb_reg)) ? -q_raw : q_raw;
        r_fix = (signed_reg && a_msb_reg) ? -r_raw : r_raw;
    end

    // Next-state and datapath control; every register holds unless changed.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        work_next   = work_reg;
        b_mag_next  = b_mag_reg;
        signed_next = signed_reg;
        a_msb_next  = a_msb_reg;
        b_msb_next  = b_msb_reg;
        result_next = result_reg;
        ready_next  = ready_reg;
        case (state_reg)
            DIV_FREE: begin
                result_next = '0;
                ready_next  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && annul_i != DIV_ANNUL) begin
                    if (opdata2_i == '0) begin
                        state_next = DIV_BYZERO;
                    end else begin
                        b_mag_next  = b_mag;
                        signed_next = signed_div_i;
                        a_msb_next  = opdata1_i[DATA_W-1];
                        b_msb_next  = opdata2_i[DATA_W-1];
                        cnt_next    = '0;
                        work_next   = {{DATA_W{1'b0}}, a_mag, 1'b0};
                        state_next  = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i == DIV_ANNUL) begin
                    state_next = DIV_FREE;
                end else begin
                    result_next = '0;
                    ready_next  = DIV_RESULT_READY;
                    state_next  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i == DIV_ANNUL) begin
                    state_next = DIV_FREE;
                end else if (cnt_reg != CNT_W'(DATA_W)) begin
                    work_next = step_work;
                    cnt_next  = cnt_reg + 1'b1;
                end else begin
                    result_next = {r_fix, q_fix};
                    ready_next  = DIV_RESULT_READY;
                    state_next  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                    state_next  = DIV_FREE;
                end
            end
            default: state_next = DIV_FREE;
        endcase
    end

    // State and datapath registers; reset overrides start and annul.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= DIV_FREE;
            cnt_reg    <= '0;
            work_reg   <= '0;
            b_mag_reg  <= '0;
            signed_reg <= 1'b0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            result_reg <= '0;
            ready_reg  <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            work_reg   <= work_next;
            b_mag_reg  <= b_mag_next;
            signed_reg <= signed_next;
            a_msb_reg  <= a_msb_next;
            b_msb_reg  <= b_msb_next;
            result_reg <= result_next;
            ready_reg  <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results computed
// with plain 64-bit arithmetic; a negedge monitor pops and compares them.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] res;
        int          accept;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic        prev_ready = 1'b0;
    logic [63:0] last_res = '0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: truncating division on sign/zero-extended 64-bit values,
    // so 0x80000000 / -1 needs no special case. Zero divisor yields 0.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint al, bl, ql, rl;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        al = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        bl = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        ql = al / bl;
        rl = al % bl;
        qv = ql;
        rv = rl;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops on each rising ready, checks result and latency, then
    // checks the result stays put while ready is held and is 0 otherwise.
    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready got=%h expected=none", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("latency", 64'(cyc - e.accept), 64'(e.lat));
                $display("txn result=%h latency=%0d", result_o, cyc - e.accept);
            end
            last_res = result_o;
        end else if (ready_o && prev_ready) begin
            check("result_stable", result_o, last_res);
        end else if (!ready_o) begin
            check("idle_result_zero", result_o, 64'd0);
        end
        prev_ready = ready_o;
    end

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        exp_t e;
        bit   seen;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res    = ref_div(sgn, a, b);
        e.accept = cyc + 1;
        e.lat    = (b == 32'd0) ? 1 : 33;
        sb.push_back(e);
        seen = 0;
        for (int w = 0; w < 80 && !seen; w++) begin
            @(negedge clk);
            // Operands after acceptance must not matter.
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
            if (ready_o) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=0 expected=1 a=%h b=%h", a, b);
            sb.delete();
        end
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("ready_drop", 64'(ready_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, 0);
        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 1);
        do_div(1'b0, 32'hFFFFFFF9, 32'h00000002, 0);
        do_div(1'b0, 32'h12345678, 32'h0, 2);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 5);

        // Annul mid-divide: no result, then a fresh start completes normally.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'd0);
        do_div(1'b0, 32'd1000, 32'd3, 0);

        // Annul in BYZERO drops the zero-divisor result.
        @(negedge clk);
        opdata2_i = 32'd0; start_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_byzero_ready", 64'(ready_o), 64'd0);

        // Annul in FREE blocks acceptance; any late ready is unexpected.
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        repeat (40) @(negedge clk);
        check("annul_free_ready", 64'(ready_o), 64'd0);

        // Reset mid-divide clears outputs; the next start works.
        @(negedge clk);
        signed_div_i = 1'b1; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd9; start_i = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_ready", 64'(ready_o), 64'd0);
        check("midreset_result", result_o, 64'd0);
        start_i = 1'b0;
        rst = 1'b0;
        do_div(1'b1, 32'hDEADBEEF, 32'd9, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            do_div(1'($urandom), a, b, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
